// File: rtl/output_drain_pkg.sv
// Shared widths and drain FSM encoding for the output read-out path.
// Common with the matmul top and the memory models.
package output_drain_pkg;

    localparam int unsigned DWIDTH       = 8;
    localparam int unsigned MAT_MUL_SIZE = 4;
    localparam int unsigned AWIDTH       = 10;
    localparam int unsigned ROW_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } drain_state_t;

    // Row requests above the matrix height saturate at the height.
    function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] n,
                                                    input int unsigned     limit);
        logic [ROW_W-1:0] lim;
        lim = ROW_W'(limit);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/output_drain_if.sv
// Host control, BRAM read port and byte stream of the output drain.
// master = host/DMA/BRAM side, slave = the drain engine.
interface output_drain_if
    import output_drain_pkg::*;
#(
    parameter int unsigned DWIDTH       = output_drain_pkg::DWIDTH,
    parameter int unsigned MAT_MUL_SIZE = output_drain_pkg::MAT_MUL_SIZE,
    parameter int unsigned AWIDTH       = output_drain_pkg::AWIDTH
) ();

    logic                           start;
    logic [AWIDTH-1:0]              base_addr;
    logic [ROW_W-1:0]               num_rows;
    logic [AWIDTH-1:0]              addr_stride;
    logic                           busy;
    logic                           done;

    logic                           rd_en;
    logic [AWIDTH-1:0]              rd_addr;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] rd_data;

    logic                           out_valid;
    logic                           out_ready;
    logic [DWIDTH-1:0]              out_data;
    logic                           out_last;

    modport master (
        output start, base_addr, num_rows, addr_stride, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_last
    );

    modport slave (
        input  start, base_addr, num_rows, addr_stride, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_last
    );

endinterface

// File: rtl/output_drain_serializer.sv
// Row buffer and element serializer: turns one BRAM word into
// MAT_MUL_SIZE valid/ready beats, element 0 from the low byte.
module drain_serializer
    import output_drain_pkg::*;
#(
    parameter int unsigned DWIDTH       = output_drain_pkg::DWIDTH,
    parameter int unsigned MAT_MUL_SIZE = output_drain_pkg::MAT_MUL_SIZE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_load,
    input  logic                           i_last_row,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] i_rd_data,
    input  logic                           i_ready,
    output logic                           o_valid,
    output logic [DWIDTH-1:0]              o_data,
    output logic                           o_last,
    output logic                           o_row_done
);

    localparam int unsigned      IDX_W    = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_MUL_SIZE - 1);

    logic [MAT_MUL_SIZE-1:0][DWIDTH-1:0] r_buf;
    logic [IDX_W-1:0]                    r_idx;
    logic                                r_valid;
    logic                                r_last_row;
    logic                                w_at_last;

    assign w_at_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf      <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_last_row <= 1'b0;
        end else if (i_load) begin
            r_buf      <= i_rd_data;
            r_idx      <= '0;
            r_valid    <= 1'b1;
            r_last_row <= i_last_row;
        end else if (r_valid && i_ready) begin
            if (w_at_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Data/last only move on a handshake, so they hold through stalls.
    assign o_valid    = r_valid;
    assign o_data     = r_buf[r_idx];
    assign o_last     = r_valid && r_last_row && w_at_last;
    assign o_row_done = r_valid && i_ready && w_at_last;

endmodule

// File: rtl/output_drain.sv
// Output BRAM drain: walks result rows from base_addr by addr_stride and
// streams each row's elements out through drain_serializer.
module output_drain
    import output_drain_pkg::*;
#(
    parameter int unsigned DWIDTH       = output_drain_pkg::DWIDTH,
    parameter int unsigned MAT_MUL_SIZE = output_drain_pkg::MAT_MUL_SIZE,
    parameter int unsigned AWIDTH       = output_drain_pkg::AWIDTH
) (
    input logic           clk,
    input logic           reset,
    output_drain_if.slave bus
);

    drain_state_t      r_state;
    logic [ROW_W-1:0]  r_rows;
    logic [ROW_W-1:0]  r_row;
    logic [AWIDTH-1:0] r_row_addr;
    logic [AWIDTH-1:0] r_stride;
    logic              r_rd_en;
    logic [AWIDTH-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;

    logic [ROW_W-1:0]  w_rows_clamped;
    logic [AWIDTH-1:0] w_next_addr;
    logic              w_load;
    logic              w_last_row;
    logic              w_row_done;
    logic              w_out_valid;
    logic [DWIDTH-1:0] w_out_data;
    logic              w_out_last;

    assign w_rows_clamped = clamp_rows(bus.num_rows, MAT_MUL_SIZE);
    assign w_next_addr    = r_row_addr + r_stride;
    assign w_load         = (r_state == ST_WAIT);
    assign w_last_row     = (r_row == (r_rows - ROW_W'(1)));

    // Row address is accumulated, so the modulo-2^AWIDTH wrap is implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rows     <= '0;
            r_row      <= '0;
            r_row_addr <= '0;
            r_stride   <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_rows     <= w_rows_clamped;
                        r_stride   <= bus.addr_stride;
                        r_row      <= '0;
                        r_row_addr <= bus.base_addr;
                        r_busy     <= 1'b1;
                        if (w_rows_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_READ;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= bus.base_addr;
                        end
                    end
                end
                ST_READ: r_state <= ST_WAIT;
                ST_WAIT: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_row_done) begin
                        if (w_last_row) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_READ;
                            r_row      <= r_row + ROW_W'(1);
                            r_row_addr <= w_next_addr;
                            r_rd_en    <= 1'b1;
                            r_rd_addr  <= w_next_addr;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    drain_serializer #(
        .DWIDTH       (DWIDTH),
        .MAT_MUL_SIZE (MAT_MUL_SIZE)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_last_row (w_last_row),
        .i_rd_data  (bus.rd_data),
        .i_ready    (bus.out_ready),
        .o_valid    (w_out_valid),
        .o_data     (w_out_data),
        .o_last     (w_out_last),
        .o_row_done (w_row_done)
    );

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_output_drain.sv
// Scoreboard bench for output_drain: expected bytes/addresses are queued
// from a BRAM model when a drain is started, then matched against the stream.
module tb_output_drain;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    output_drain_if #(.DWIDTH(8), .MAT_MUL_SIZE(4), .AWIDTH(10)) bus ();

    output_drain #(.DWIDTH(8), .MAT_MUL_SIZE(4), .AWIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_data[$];
    logic [7:0] obs_data[$];
    bit         exp_last[$];
    bit         obs_last[$];
    logic [9:0] exp_addr[$];
    logic [9:0] obs_addr[$];

    int done_n, first_valid_n, valid_cnt, rden_cnt, stall_err, last_err;
    bit busy_at_done, post_done, post_busy;

    function automatic bit rdy(input bit bp, input int c);
        return bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
    endfunction

    task automatic load_spec_matrix();
        mem[0] = 32'h22525A62;
        mem[1] = 32'h1A333F4B;
        mem[2] = 32'h132C303E;
        mem[3] = 32'h0D2E2836;
    endtask

    task automatic expect_drain(input logic [9:0] base, input logic [2:0] rows,
                                input logic [9:0] stride);
        int          rc;
        logic [9:0]  a;
        logic [31:0] w;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        rc = (rows > 3'd4) ? 4 : int'(rows);
        for (int r = 0; r < rc; r++) begin
            a = 10'(int'(base) + r * int'(stride));
            exp_addr.push_back(a);
            w = mem[a];
            for (int e = 0; e < 4; e++) begin
                exp_data.push_back(w[e*8 +: 8]);
                exp_last.push_back((r == rc - 1) && (e == 3));
            end
        end
    endtask

    task automatic run_drain(input logic [9:0] base, input logic [2:0] rows,
                             input logic [9:0] stride, input bit bp,
                             input bit inject, input int max_cycles);
        int         n, cnt;
        bit         prev_stall;
        logic [7:0] prev_data;
        bit         prev_last;
        obs_data.delete(); obs_last.delete(); obs_addr.delete();
        done_n = 0; first_valid_n = 0; valid_cnt = 0; rden_cnt = 0;
        stall_err = 0; last_err = 0; busy_at_done = 0;
        @(posedge clk); #1;
        cnt = 0;
        bus.base_addr = base; bus.num_rows = rows; bus.addr_stride = stride;
        bus.start = 1'b1; bus.out_ready = rdy(bp, cnt);
        @(posedge clk); #1;
        cnt++;
        bus.start = 1'b0; bus.out_ready = rdy(bp, cnt);
        bus.base_addr = base ^ 10'h2AA; bus.num_rows = 3'd1; bus.addr_stride = stride + 10'd5;
        n = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        while (n < max_cycles && done_n == 0) begin
            @(negedge clk);
            n++;
            if (bus.rd_en) begin rden_cnt++; obs_addr.push_back(bus.rd_addr); end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_valid_n == 0) first_valid_n = n;
            end
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
                stall_err++;
            if (bus.out_last && !bus.out_valid) last_err++;
            if (bus.out_valid && bus.out_ready) begin
                obs_data.push_back(bus.out_data);
                obs_last.push_back(bus.out_last);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.done) begin done_n = n; busy_at_done = bus.busy; end
            @(posedge clk); #1;
            cnt++;
            bus.out_ready = rdy(bp, cnt);
            bus.start = inject && (n == 5);
        end
        bus.start = 1'b0;
        @(negedge clk);
        post_done = bus.done;
        post_busy = bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en); end
        n_cmp++; if (bus.rd_addr !== 10'd0) begin n_err++; $display("FAIL reset_rd_addr: got %h expected 0", bus.rd_addr); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        #1 reset = 1'b0;
    endtask

    task automatic test_single_drain();
        load_spec_matrix();
        expect_drain(10'd0, 3'd4, 10'd1);
        run_drain(10'd0, 3'd4, 10'd1, 1'b0, 1'b0, 40);
        n_cmp++; if (done_n !== 25) begin n_err++; $display("FAIL single_done_cycle: got %0d expected 25", done_n); end
        n_cmp++; if (first_valid_n !== 3) begin n_err++; $display("FAIL single_first_valid: got %0d expected 3", first_valid_n); end
        n_cmp++; if (busy_at_done !== 1'b1) begin n_err++; $display("FAIL single_busy_at_done: got %b expected 1", busy_at_done); end
        n_cmp++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin n_err++; $display("FAIL single_after_done: got done %b busy %b expected 0 0", post_done, post_busy); end
        n_cmp++; if (last_err !== 0) begin n_err++; $display("FAIL single_last_without_valid: got %0d expected 0", last_err); end
        n_cmp++; if (obs_data.size() !== exp_data.size()) begin n_err++; $display("FAIL single_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL single_byte[%0d]: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        load_spec_matrix();
        expect_drain(10'd0, 3'd4, 10'd1);
        run_drain(10'd0, 3'd4, 10'd1, 1'b1, 1'b0, 150);
        n_cmp++; if (done_n <= 25) begin n_err++; $display("FAIL bp_done_cycle: got %0d expected >25 and completed", done_n); end
        n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL bp_stall_stability: got %0d violations expected 0", stall_err); end
        n_cmp++; if (obs_data.size() !== exp_data.size()) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL bp_byte[%0d]: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_stride_wrap();
        mem[1022] = $urandom; mem[1023] = $urandom; mem[0] = $urandom; mem[1] = $urandom;
        expect_drain(10'd1022, 3'd4, 10'd1);
        run_drain(10'd1022, 3'd4, 10'd1, 1'b0, 1'b0, 40);
        n_cmp++; if (obs_addr.size() !== 4) begin n_err++; $display("FAIL wrap_addr_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_addr[i]); end
        end
        n_cmp++; if (obs_data.size() !== exp_data.size()) begin n_err++; $display("FAIL wrap_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i]) begin n_err++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, obs_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_clamp_stride();
        for (int a = 8; a < 18; a++) mem[a] = $urandom;
        expect_drain(10'd8, 3'd7, 10'd3);
        run_drain(10'd8, 3'd7, 10'd3, 1'b0, 1'b0, 40);
        n_cmp++; if (done_n !== 25) begin n_err++; $display("FAIL clamp_done_cycle: got %0d expected 25", done_n); end
        n_cmp++; if (obs_addr.size() !== exp_addr.size()) begin n_err++; $display("FAIL clamp_addr_count: got %0d expected %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL clamp_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_addr[i]); end
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL clamp_byte[%0d]: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_zero_rows();
        run_drain(10'd5, 3'd0, 10'd1, 1'b0, 1'b0, 10);
        n_cmp++; if (done_n !== 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d expected 1", done_n); end
        n_cmp++; if (rden_cnt !== 0) begin n_err++; $display("FAIL zero_rd_en: got %0d cycles expected 0", rden_cnt); end
        n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL zero_out_valid: got %0d cycles expected 0", valid_cnt); end
        n_cmp++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin n_err++; $display("FAIL zero_after_done: got done %b busy %b expected 0 0", post_done, post_busy); end
    endtask

    task automatic test_two_rows();
        mem[0] = $urandom; mem[2] = $urandom;
        expect_drain(10'd0, 3'd2, 10'd2);
        run_drain(10'd0, 3'd2, 10'd2, 1'b0, 1'b0, 30);
        n_cmp++; if (done_n !== 13) begin n_err++; $display("FAIL two_done_cycle: got %0d expected 13", done_n); end
        n_cmp++; if (obs_data.size() !== 8) begin n_err++; $display("FAIL two_count: got %0d expected 8", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL two_byte[%0d]: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        load_spec_matrix();
        expect_drain(10'd0, 3'd4, 10'd1);
        run_drain(10'd0, 3'd4, 10'd1, 1'b0, 1'b1, 40);
        n_cmp++; if (done_n !== 25) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d expected 25", done_n); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i]) begin n_err++; $display("FAIL busy_start_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_addr[i]); end
        end
        n_cmp++; if (obs_data.size() !== exp_data.size()) begin n_err++; $display("FAIL busy_start_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i]) begin n_err++; $display("FAIL busy_start_byte[%0d]: got %h expected %h", i, obs_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit done_seen;
        load_spec_matrix();
        @(posedge clk); #1;
        bus.base_addr = 10'd0; bus.num_rows = 3'd4; bus.addr_stride = 10'd1;
        bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.done) done_seen = 1;
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_in_send: got valid %b expected 1", bus.out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'h00)
            begin n_err++; $display("FAIL rstmid_stream: got valid %b last %b data %h expected 0 0 00", bus.out_valid, bus.out_last, bus.out_data); end
        n_cmp++; if (bus.rd_en !== 1'b0 || bus.rd_addr !== 10'd0)
            begin n_err++; $display("FAIL rstmid_bram: got rd_en %b rd_addr %h expected 0 0", bus.rd_en, bus.rd_addr); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin n_err++; $display("FAIL rstmid_status: got busy %b done %b expected 0 0", bus.busy, bus.done); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.out_valid || bus.busy) done_seen = 1;
        end
        n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got activity %b expected 0", done_seen); end
        expect_drain(10'd0, 3'd4, 10'd1);
        run_drain(10'd0, 3'd4, 10'd1, 1'b0, 1'b0, 40);
        n_cmp++; if (done_n !== 25) begin n_err++; $display("FAIL rstmid_redrain_done: got %0d expected 25", done_n); end
        n_cmp++; if (obs_data.size() !== exp_data.size()) begin n_err++; $display("FAIL rstmid_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL rstmid_byte[%0d]: got %h last %b expected %h last %b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.num_rows    = '0;
        bus.addr_stride = '0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_single_drain();
        test_backpressure();
        test_stride_wrap();
        test_clamp_stride();
        test_zero_rows();
        test_two_rows();
        test_start_while_busy();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/output_drain.md
# output_drain

Reads the result matrix that the matmul/norm/activation/pool pipeline has written into the output BRAM and streams it out one element per handshake over a valid/ready byte stream. It is the read-out counterpart to the A/B matrix loading path: the host starts it after the pipeline signals done, and it walks the result BRAM row by row. It sits between the output BRAM read port and the host/DMA-side stream.

## Interface
Parameters:
- DWIDTH, 8, element width in bits
- MAT_MUL_SIZE, 4, elements per BRAM word (one matrix row per word)
- AWIDTH, 10, BRAM word-address width

Ports:
- clk  in  1  single clock for the block
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  AWIDTH  word address of row 0; latched on accepted start
- num_rows  in  3  rows to drain (0..MAT_MUL_SIZE); latched on accepted start
- addr_stride  in  AWIDTH  word-address increment between rows; latched on accepted start
- rd_en  out  1  BRAM read enable
- rd_addr  out  AWIDTH  BRAM read address
- rd_data  in  MAT_MUL_SIZE*DWIDTH  BRAM read data, valid one cycle after rd_en
- out_valid  out  1  stream element valid
- out_ready  in  1  stream consumer ready
- out_data  out  DWIDTH  stream element
- out_last  out  1  marks final element of the matrix
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: start=1 latches base_addr/num_rows/addr_stride, clears row counter. num_rows=0 goes to DONE; otherwise goes to READ. start while not IDLE is ignored.
- READ (1 cycle): rd_en=1, rd_addr = base_addr + row*addr_stride (modulo 2^AWIDTH); goes to WAIT.
- WAIT (1 cycle): rd_data captured into row buffer at end of cycle; element index cleared; goes to SEND.
- SEND: out_valid=1, out_data = row_buf[idx*DWIDTH +: DWIDTH] (element 0 = least-significant byte). On out_valid&&out_ready, idx increments. After element MAT_MUL_SIZE-1 handshakes: if row = num_rows-1 go to DONE, else row++ and go to READ.
- out_last=1 only while presenting element MAT_MUL_SIZE-1 of row num_rows-1.
- DONE (1 cycle): done=1; returns to IDLE. busy=1 in READ/WAIT/SEND/DONE.
- rd_en=0 and rd_addr=0 outside READ.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; state IDLE. Reset mid-drain aborts immediately; no done pulse; no stream element left valid.
- Start sampled at edge k: READ in cycle k+1, WAIT k+2, first out_valid in cycle k+3.
- With out_ready held high: 6 cycles per row (READ, WAIT, 4 SEND); full 4x4 drain = 24 cycles; done in cycle k+25.
- Stall rule: while out_valid=1 and out_ready=0, out_data/out_last held stable; out_valid never drops without a handshake.
- num_rows=0: DONE in cycle k+1, no rd_en, no out_valid.
- num_rows > MAT_MUL_SIZE (5..7) is clamped to MAT_MUL_SIZE.
- Address wrap: base_addr + row*addr_stride wraps silently modulo 2^AWIDTH.

## Structure
- Shared package/defines: DWIDTH, MAT_MUL_SIZE, AWIDTH and the state encoding, common with the matmul top and memory models.
- One natural sub-module: drain_serializer (row buffer, element index, valid/ready/last logic); the FSM and address generation stay in output_drain.

## Test plan
- Single 4x4 drain, ready always high: BRAM words at 0..3 = 0x22525A62, 0x1A333F4B, 0x132C303E, 0x0D2E2836 → stream 62 5A 52 22 4B 3F 33 1A 3E 30 2C 13 36 28 2E 0D, out_last on 0D only, done 25 cycles after start.
- Backpressure: same data, out_ready toggled 1,0,0,1 pattern → identical byte sequence, out_data stable across every stalled cycle, no drop/duplicate.
- Stride/wrap: base_addr=1022, addr_stride=1, num_rows=4 → rd_addr sequence 1022, 1023, 0, 1.
- num_rows=0 → done pulse one cycle after start, rd_en and out_valid never assert; num_rows=2 → 8 bytes, out_last on 8th.
- Start while busy → ignored, latched parameters unchanged, sequence completes normally.
- Reset asserted during SEND of row 2 → all outputs 0 asynchronously, no done; fresh start afterwards drains the full matrix correctly.
